// File: rtl/axi_uart_param_fifo.sv
// rtl/axi_uart_param_fifo.sv - parameterised FWFT FIFO with trigger, overrun and optional watermark
// Optional peak-occupancy tracking is enabled by defining AXI_FIFO_WATERMARK_EN.
module axi_uart_param_fifo #(
   parameter int DATA_SIZE  = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int OVERWRITE  = 1,
   localparam int INDEX_LENGTH = $clog2(FIFO_DEPTH)
) (
   input  logic                    clk_i,
   input  logic                    rstn_i,
   input  logic                    flush_i,
   input  logic                    push_i,
   input  logic [DATA_SIZE-1:0]    data_i,
   input  logic                    pull_i,
   output logic [DATA_SIZE-1:0]    data_o,
   output logic                    valid_o,
   output logic [INDEX_LENGTH:0]   count_o,
   output logic [INDEX_LENGTH:0]   space_o,
   output logic                    full_o,
   output logic                    empty_o,
   input  logic [INDEX_LENGTH:0]   trig_level_i,
   output logic                    trig_o,
   output logic                    overrun_o,
   input  logic                    overrun_clr_i,
   output logic [INDEX_LENGTH:0]   watermark_o
);

   localparam logic [INDEX_LENGTH:0]   DEPTH_C = (INDEX_LENGTH+1)'(FIFO_DEPTH);
   localparam logic [INDEX_LENGTH:0]   CNT_ONE = 1;
   localparam logic [INDEX_LENGTH-1:0] PTR_ONE = 1;

   logic [DATA_SIZE-1:0]    mem_q [FIFO_DEPTH];
   logic [INDEX_LENGTH-1:0] head_q, head_d, tail_q, tail_d;
   logic [INDEX_LENGTH:0]   count_q, count_d;
   logic                    trig_q, trig_d, overrun_q, overrun_d;
   logic                    is_full, is_empty, pull_acc, push_acc, head_adv, overflow;

   always_comb begin
      is_empty = (count_q == '0);
      is_full  = (count_q == DEPTH_C);
      pull_acc = pull_i && !is_empty;
      // A pull alongside a push into a full FIFO frees the slot, so only a lone push overflows.
      overflow = push_i && is_full && !pull_i;
      push_acc = push_i && (!overflow || OVERWRITE != 0);
      head_adv = pull_acc || (overflow && OVERWRITE != 0);

      head_d = head_adv ? head_q + PTR_ONE : head_q;
      tail_d = push_acc ? tail_q + PTR_ONE : tail_q;

      count_d = count_q;
      if (push_acc && !head_adv) begin
         count_d = count_q + CNT_ONE;
      end else if (!push_acc && head_adv) begin
         count_d = count_q - CNT_ONE;
      end

      overrun_d = overflow || (overrun_q && !overrun_clr_i);
      trig_d    = (trig_level_i != '0) && (count_d >= trig_level_i);

      if (flush_i) begin
         head_d    = '0;
         tail_d    = '0;
         count_d   = '0;
         overrun_d = 1'b0;
         trig_d    = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
         trig_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         trig_q    <= trig_d;
         overrun_q <= overrun_d;
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk_i) begin
      if (rstn_i && !flush_i && push_acc) begin
         mem_q[tail_q] <= data_i;
      end
   end

`ifdef AXI_FIFO_WATERMARK_EN
   logic [INDEX_LENGTH:0] watermark_q, watermark_d;

   always_comb begin
      watermark_d = (count_d > watermark_q) ? count_d : watermark_q;
      if (flush_i) begin
         watermark_d = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         watermark_q <= '0;
      end else begin
         watermark_q <= watermark_d;
      end
   end

   assign watermark_o = watermark_q;
`else
   assign watermark_o = '0;
`endif

   assign data_o    = is_empty ? '0 : mem_q[head_q];
   assign valid_o   = !is_empty;
   assign count_o   = count_q;
   assign space_o   = DEPTH_C - count_q;
   assign full_o    = is_full;
   assign empty_o   = is_empty;
   assign trig_o    = trig_q;
   assign overrun_o = overrun_q;

endmodule

// File: tb/tb_axi_uart_param_fifo.sv
// tb/tb_axi_uart_param_fifo.sv - self-checking bench for both overflow policies of axi_uart_param_fifo
module tb_axi_uart_param_fifo;

   localparam int D = 16;

   logic       clk = 1'b0;
   logic       rstn, flush, push, pull, clr;
   logic [7:0] din;
   logic [4:0] lvl;

   logic [7:0] data_o [2];
   logic       valid [2], full [2], empty [2], trig [2], ov [2];
   logic [4:0] cnt [2], space [2], wm [2];

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   axi_uart_param_fifo #(.DATA_SIZE(8), .FIFO_DEPTH(D), .OVERWRITE(1)) u_ow (
      .clk_i(clk), .rstn_i(rstn), .flush_i(flush), .push_i(push), .data_i(din), .pull_i(pull),
      .data_o(data_o[0]), .valid_o(valid[0]), .count_o(cnt[0]), .space_o(space[0]),
      .full_o(full[0]), .empty_o(empty[0]), .trig_level_i(lvl), .trig_o(trig[0]),
      .overrun_o(ov[0]), .overrun_clr_i(clr), .watermark_o(wm[0]));

   axi_uart_param_fifo #(.DATA_SIZE(8), .FIFO_DEPTH(D), .OVERWRITE(0)) u_dc (
      .clk_i(clk), .rstn_i(rstn), .flush_i(flush), .push_i(push), .data_i(din), .pull_i(pull),
      .data_o(data_o[1]), .valid_o(valid[1]), .count_o(cnt[1]), .space_o(space[1]),
      .full_o(full[1]), .empty_o(empty[1]), .trig_level_i(lvl), .trig_o(trig[1]),
      .overrun_o(ov[1]), .overrun_clr_i(clr), .watermark_o(wm[1]));

   // Reference model: index 0 overwrites when full, index 1 discards.
   logic [7:0] mq [2][$];
   bit         mov [2];
   bit         mtrig [2];
   int         mwm [2];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         int c;
         bit ovf;
         if (!rstn || flush) begin
            mq[k].delete();
            mov[k] = 0;
            mtrig[k] = 0;
            mwm[k] = 0;
         end else begin
            c = mq[k].size();
            ovf = 0;
            if (push && !pull && c == D) begin
               ovf = 1;
               if (k == 0) begin
                  void'(mq[k].pop_front());
                  mq[k].push_back(din);
               end
            end else begin
               if (pull && c > 0) void'(mq[k].pop_front());
               if (push) mq[k].push_back(din);
            end
            if (ovf) mov[k] = 1;
            else if (clr) mov[k] = 0;
            mtrig[k] = (lvl != 0) && (mq[k].size() >= int'(lvl));
`ifdef AXI_FIFO_WATERMARK_EN
            if (mq[k].size() > mwm[k]) mwm[k] = mq[k].size();
`endif
         end
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < 2; k++) begin
         int n;
         n = mq[k].size();
         chk($sformatf("count[%0d]", k), cnt[k], n);
         chk($sformatf("space[%0d]", k), space[k], D - n);
         chk($sformatf("data[%0d]", k), data_o[k], (n > 0) ? mq[k][0] : 8'h00);
         chk($sformatf("valid[%0d]", k), valid[k], n != 0);
         chk($sformatf("full[%0d]", k), full[k], n == D);
         chk($sformatf("empty[%0d]", k), empty[k], n == 0);
         chk($sformatf("trig[%0d]", k), trig[k], mtrig[k]);
         chk($sformatf("overrun[%0d]", k), ov[k], mov[k]);
         chk($sformatf("watermark[%0d]", k), wm[k], mwm[k]);
      end
   endtask

   task automatic cyc(input bit p, input bit q, input bit f, input bit c, input logic [7:0] d);
      push = p; pull = q; flush = f; clr = c; din = d;
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
   endtask

   typedef struct {
      bit         push, pull, flush;
      logic [7:0] d;
      int         e_cnt;
      logic [7:0] e_data;
      bit         e_trig;
   } vec_t;

   vec_t tbl [17];

   initial begin
      tbl[0]  = '{1, 0, 0, 8'h11, 1, 8'h11, 0};
      tbl[1]  = '{1, 0, 0, 8'h22, 2, 8'h11, 0};
      tbl[2]  = '{1, 0, 0, 8'h33, 3, 8'h11, 0};
      tbl[3]  = '{0, 1, 0, 8'h00, 2, 8'h22, 0};
      tbl[4]  = '{0, 1, 0, 8'h00, 1, 8'h33, 0};
      tbl[5]  = '{0, 1, 0, 8'h00, 0, 8'h00, 0};
      tbl[6]  = '{0, 1, 0, 8'h00, 0, 8'h00, 0};
      tbl[7]  = '{1, 0, 0, 8'hA1, 1, 8'hA1, 0};
      tbl[8]  = '{1, 0, 0, 8'hA2, 2, 8'hA1, 0};
      tbl[9]  = '{1, 0, 0, 8'hA3, 3, 8'hA1, 0};
      tbl[10] = '{1, 0, 0, 8'hA4, 4, 8'hA1, 1};
      tbl[11] = '{0, 1, 0, 8'h00, 3, 8'hA2, 0};
      tbl[12] = '{1, 1, 0, 8'hB1, 3, 8'hA3, 0};
      tbl[13] = '{1, 0, 1, 8'hC1, 0, 8'h00, 0};
      tbl[14] = '{1, 1, 0, 8'hD5, 1, 8'hD5, 0};
      tbl[15] = '{1, 1, 0, 8'hE6, 1, 8'hE6, 0};
      tbl[16] = '{0, 0, 1, 8'h00, 0, 8'h00, 0};

      rstn = 1'b0; lvl = 5'd4;
      cyc(0, 0, 0, 0, 8'h00);
      cyc(1, 1, 1, 0, 8'hFF);
      rstn = 1'b1;
      cyc(0, 0, 0, 0, 8'h00);

      for (int i = 0; i < 17; i++) begin
         cyc(tbl[i].push, tbl[i].pull, tbl[i].flush, 1'b0, tbl[i].d);
         for (int k = 0; k < 2; k++) begin
            chk($sformatf("vec%0d count[%0d]", i, k), cnt[k], tbl[i].e_cnt);
            chk($sformatf("vec%0d data[%0d]", i, k), data_o[k], tbl[i].e_data);
            chk($sformatf("vec%0d trig[%0d]", i, k), trig[k], tbl[i].e_trig);
         end
      end

      // Seventeen pushes into a 16-deep FIFO, trigger disabled.
      lvl = 5'd0;
      for (int i = 0; i <= 16; i++) cyc(1, 0, 0, 0, 8'(i));
      chk("ovf count_ow", cnt[0], 16);
      chk("ovf count_dc", cnt[1], 16);
      chk("ovf overrun_ow", ov[0], 1);
      chk("ovf overrun_dc", ov[1], 1);
      chk("ovf head_ow", data_o[0], 8'h01);
      chk("ovf head_dc", data_o[1], 8'h00);
      chk("lvl0 trig_ow", trig[0], 0);
      cyc(0, 0, 0, 1, 8'h00);
      chk("clr overrun_ow", ov[0], 0);
      chk("clr overrun_dc", ov[1], 0);
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("drain%0d_ow", i), data_o[0], 8'(i + 1));
         chk($sformatf("drain%0d_dc", i), data_o[1], 8'(i));
         cyc(0, 1, 0, 0, 8'h00);
      end
      chk("drained empty", empty[0] && empty[1], 1);

      // Full push+pull: both accepted, no overrun.
      for (int i = 0; i < 16; i++) cyc(1, 0, 0, 0, 8'(8'h40 + i));
      cyc(1, 1, 0, 0, 8'h55);
      chk("full pp count", cnt[0], 16);
      chk("full pp overrun", ov[0] | ov[1], 0);
      chk("full pp head", data_o[0], 8'h41);
      // Overflow and clear in the same cycle keeps the flag set.
      cyc(1, 0, 0, 1, 8'h66);
      chk("ovf+clr overrun", ov[0] & ov[1], 1);

      // Flush, fill to 9, drain to 2.
      cyc(1, 0, 1, 0, 8'h77);
      chk("flush count", cnt[0], 0);
      chk("flush overrun", ov[0], 0);
      for (int i = 0; i < 9; i++) cyc(1, 0, 0, 0, 8'(i));
      for (int i = 0; i < 7; i++) cyc(0, 1, 0, 0, 8'h00);
      chk("wm count", cnt[0], 2);
`ifdef AXI_FIFO_WATERMARK_EN
      chk("watermark", wm[0], 9);
`else
      chk("watermark", wm[0], 0);
`endif

      // Randomised traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         bit hi;
         hi = ((i / 200) % 2) == 0;
         rstn = ($urandom_range(0, 499) != 0);
         if ($urandom_range(0, 49) == 0) lvl = 5'($urandom_range(0, 20));
         cyc($urandom_range(0, 99) < (hi ? 75 : 25),
             $urandom_range(0, 99) < (hi ? 25 : 75),
             $urandom_range(0, 99) == 0,
             $urandom_range(0, 19) == 0,
             8'($urandom));
      end
      rstn = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
